// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory BIST sequencer: FSM state encoding,
// RAM read latency and the seed-derived fill pattern.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam int RD_LAT = 1;

    // Widest data word the pattern helper supports; callers truncate to DATA_W.
    localparam int BIST_MAX_W = 64;

    function automatic logic [BIST_MAX_W-1:0] bist_pattern(
        input logic [BIST_MAX_W-1:0] seed,
        input logic [BIST_MAX_W-1:0] addr,
        input logic                  mode
    );
        logic [BIST_MAX_W-1:0] sum;
        sum = seed + addr;
        return mode ? ~sum : sum;
    endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// RAM-side bus between the BIST sequencer (master) and a single-port RAM (slave).
interface mem_bist_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Strobe semantics, no back-pressure: mem_we writes mem_din to mem_addr at the
    // clock edge; mem_rd samples mem_addr at the edge and mem_dout holds that word
    // for the whole following cycle. The RAM accepts every strobe.
    logic              mem_we;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_we,
        output mem_rd,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_we,
        input  mem_rd,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_bist_checker.sv
// Compares returned RAM words against the expected pattern and keeps the
// saturating mismatch count plus the address of the first mismatch.
module mem_bist_checker #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cmp_valid,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              clean_next
);

    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic              mismatch;

    always_comb begin
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        mismatch         = cmp_valid && (rd_data != exp_data);
        if (clear) begin
            err_cnt_d        = '0;
            first_err_addr_d = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + (ADDR_W + 1)'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_addr_d = exp_addr;
            end
        end
        // Lets the sequencer decide pass in the same edge as the final compare.
        clean_next = (err_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else begin
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Fill-and-verify sequencer: writes a seed-derived pattern over 0..LAST_ADDR,
// reads it back through a 1-cycle RAM and reports pass, error count and first bad address.
module mem_bist_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [DATA_W-1:0]      seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDR_W:0]        err_cnt,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [2:0]             dbg_state,
    mem_bist_ctrl_if.master        mem
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              mode_q, mode_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [RD_LAT-1:0] cmp_pipe_q, cmp_pipe_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              aborting;
    logic              chk_clear;
    logic              chk_valid;
    logic              chk_clean_next;

    function automatic logic [DATA_W-1:0] pat(
        input logic [DATA_W-1:0] s,
        input logic [ADDR_W-1:0] a,
        input logic              m
    );
        logic [BIST_MAX_W-1:0] w;
        w = bist_pattern(BIST_MAX_W'(s), BIST_MAX_W'(a), m);
        return w[DATA_W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        seed_d     = seed_q;
        mode_d     = mode_q;
        we_d       = 1'b0;
        rd_d       = 1'b0;
        din_d      = din_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        cmp_pipe_d = '0;
        exp_d      = exp_q;
        exp_addr_d = exp_addr_q;
        chk_clear  = 1'b0;
        addr_inc   = addr_q + ADDR_W'(1);
        aborting   = abort && (state_q != ST_IDLE);
        // An abort also kills the compare that would land on this edge.
        chk_valid  = cmp_pipe_q[RD_LAT-1] && !aborting;

        if (aborting) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            cmp_pipe_d = RD_LAT'({cmp_pipe_q, rd_q});
            if (rd_q) begin
                exp_d      = pat(seed_q, addr_q, mode_q);
                exp_addr_d = addr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_d    = seed;
                        mode_d    = mode;
                        addr_d    = '0;
                        chk_clear = 1'b1;
                        pass_d    = 1'b0;
                        busy_d    = 1'b1;
                        we_d      = 1'b1;
                        din_d     = pat(seed, '0, mode);
                        state_d   = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        rd_d    = 1'b1;
                        state_d = ST_READ;
                    end else begin
                        addr_d = addr_inc;
                        we_d   = 1'b1;
                        din_d  = pat(seed_q, addr_inc, mode_q);
                    end
                end
                ST_READ: begin
                    if (addr_q == LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_inc;
                        rd_d   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = chk_clean_next;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            seed_q     <= '0;
            mode_q     <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cmp_pipe_q <= '0;
            exp_q      <= '0;
            exp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            seed_q     <= seed_d;
            mode_q     <= mode_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            cmp_pipe_q <= cmp_pipe_d;
            exp_q      <= exp_d;
            exp_addr_q <= exp_addr_d;
        end
    end

    mem_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (chk_clear),
        .cmp_valid      (chk_valid),
        .exp_data       (exp_q),
        .exp_addr       (exp_addr_q),
        .rd_data        (mem.mem_dout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .clean_next     (chk_clean_next)
    );

    assign mem.mem_we   = we_q;
    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Fill-and-verify sequencer for one synchronous single-port `ram_test` instance (1024 x 32, 1-cycle read latency). On `start` it writes a seed-derived pattern to every address from 0 to `LAST_ADDR`, reads the range back, and compares each word. It then reports pass/fail, the error count and the first failing address. It sits between the top-level test logic and the RAM, and fully owns the RAM's `we`/`rd`/`addr`/`din` while busy.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width.
- `DATA_W`, 32: RAM data width.
- `LAST_ADDR`, 1023: last address exercised. Must be less than 2^ADDR_W. Simulation uses 6.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a run; sampled only in IDLE.
- `abort`  in  1: cancel a run; sampled in any non-IDLE state.
- `mode`  in  1: pattern select, sampled at start. 0 = `seed+addr`; 1 = `~(seed+addr)`.
- `seed`  in  DATA_W: pattern seed, sampled at start.
- `busy`  out  1: high from the cycle after start is accepted through DRAIN.
- `done`  out  1: single-cycle pulse when a run completes (not on abort).
- `pass`  out  1: high when the last completed run had 0 errors. Held until the next start.
- `err_cnt`  out  ADDR_W+1: mismatch count; saturates at all-ones.
- `first_err_addr`  out  ADDR_W: address of the first mismatch; 0 if none.
- `mem_we`, `mem_rd`  out  1: RAM write enable and read strobe.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_din`  out  DATA_W: RAM write data.
- `mem_dout`  in  DATA_W: RAM read data, valid 1 cycle after `mem_rd`.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: when `start`=1, latch `seed` and `mode`, clear `err_cnt`, `first_err_addr` and `pass`, set `mem_addr`=0, and go to WRITE.
- WRITE: `mem_we`=1 and `mem_din`=pattern(`mem_addr`).
  - When `mem_addr`==`LAST_ADDR`, set `mem_addr`=0 and go to READ.
  - Otherwise increment `mem_addr`.
- READ: `mem_rd`=1 and `mem_we`=0.
  - The expected word and address are delayed 1 cycle to align with `mem_dout`.
  - When `mem_addr`==`LAST_ADDR`, go to DRAIN; otherwise increment `mem_addr`.
- DRAIN: `mem_rd`=0. Compare the last returned word, then go to DONE.
- DONE: `done`=1 for one cycle, `pass`=(`err_cnt`==0), then go to IDLE.
- Compare-valid is `mem_rd` delayed by 1 cycle. On each valid mismatch:
  - `err_cnt` increments, saturating.
  - `first_err_addr` is loaded only if `err_cnt` was 0.
- Pattern arithmetic: `seed` + zero-extended address, mod 2^DATA_W. Wrap-around is silent.
- `abort` while non-IDLE:
  - Next cycle the block is in IDLE with `mem_we`=`mem_rd`=0 and `busy`=0.
  - No `done` pulse; `pass`=0.
  - `err_cnt` and `first_err_addr` keep their partial values.
  - Any in-flight compare is discarded.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `start` wins.
- `LAST_ADDR`=0 is legal: 1 write cycle and 1 read cycle.

## Timing
- Reset (async, `rst_n`=0): state=IDLE and every output is 0, including `mem_we`, `mem_rd`, `mem_addr`, `mem_din`, `pass`, `err_cnt` and `first_err_addr`.
- All outputs are registered. `mem_we` drops asynchronously on reset mid-write; a partial RAM state is acceptable.
- With N = `LAST_ADDR`+1 and `start` sampled at edge k:
  - WRITE occupies cycles k+1 .. k+N.
  - READ occupies cycles k+N+1 .. k+2N.
  - DRAIN occupies cycle k+2N+1.
  - `done` is high in cycle k+2N+2.
  - Total latency from start to done: 2N+2 cycles.
- Read latency is fixed at 1 (`RD_LAT`). `mem_dout` is sampled in the cycle after `mem_rd`.
- No bubbles between the last WRITE and the first READ.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state encoding (3-bit constants `ST_IDLE` .. `ST_DONE`),
  - `RD_LAT`=1,
  - the pattern function `bist_pattern(seed, addr, mode)`.
- Sub-module `mem_bist_checker`: takes compare-valid, expected data, delayed address and `mem_dout`; owns `err_cnt` and `first_err_addr`, with a synchronous clear input.
- The top level holds the FSM and the address/pattern generation.

## Test plan
- `LAST_ADDR`=6, `seed`=0, `mode`=0, fault-free RAM -> RAM holds 0..6 at addresses 0..6; `done` at cycle k+16; `pass`=1; `err_cnt`=0.
- `seed`=32'hFFFFFFFE, `mode`=1 -> address 2 holds `~0`=32'hFFFFFFFF (the sum wraps to 0); `pass`=1.
- Bench RAM model flips bit 0 on reads of addresses 3 and 5 -> `err_cnt`=2, `first_err_addr`=3, `pass`=0.
- `abort` in the 2nd READ cycle -> IDLE next cycle, `busy`=0, no `done` pulse, `pass`=0; a later `start` runs cleanly to `pass`=1.
- `rst_n` low mid-WRITE -> all outputs 0 immediately; `start` held high during `busy` -> no restart; back-to-back runs are accepted in IDLE.
- `LAST_ADDR`=0 -> exactly 1 `mem_we` cycle and 1 `mem_rd` cycle; `done` at cycle k+4.
